// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : DLFloat16 field layout, saturation constants and accumulator
//                state encoding shared by the streaming FP accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

   localparam int SIGN_W   = 1;
   localparam int EXP_W    = 6;
   localparam int MANT_W   = 9;
   // {carry, hidden, mant}
   localparam int SIG_W    = MANT_W + 2;
   localparam int EXP_BIAS = 31;
   localparam int EXP_MAX  = 63;
   localparam logic [14:0] SAT_MAG = 15'h7FFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // exp==0 encodes zero, so the hidden bit is suppressed for it
   function automatic logic [SIG_W-1:0] unpack_sig(input logic [15:0] d);
      if (d[14:9] == '0) return '0;
      return {1'b0, 1'b1, d[MANT_W-1:0]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_sig_addsub.sv
// ============================================================================
//  Module      : fp_sig_addsub
//  Description : Combinational operand alignment and signed significand
//                add/subtract with carry handling and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_sig_addsub
   import fp_pkg::*;
(
   input  logic [15:0]      a_data,
   input  logic [15:0]      b_data,
   output logic             al_big_sign,
   output logic [EXP_W-1:0] al_big_exp,
   output logic [SIG_W-1:0] al_big_sig,
   output logic             al_sml_sign,
   output logic [SIG_W-1:0] al_sml_sig,
   input  logic             big_sign,
   input  logic [EXP_W-1:0] big_exp,
   input  logic [SIG_W-1:0] big_sig,
   input  logic             sml_sign,
   input  logic [SIG_W-1:0] sml_sig,
   output logic             sum_sign,
   output logic [EXP_W-1:0] sum_exp,
   output logic [9:0]       sum_sig,
   output logic             sum_zero,
   output logic             sum_sat
);

   logic             w_b_big;
   logic [15:0]      w_big;
   logic [15:0]      w_sml;
   logic [EXP_W-1:0] w_diff;
   logic             w_eff_sub;
   logic             w_swap;
   logic [SIG_W-1:0] w_raw;
   logic             w_carry;

   // ties keep the accumulator (a) as the larger operand
   always_comb begin
      w_b_big     = (b_data[14:9] > a_data[14:9]);
      w_big       = w_b_big ? b_data : a_data;
      w_sml       = w_b_big ? a_data : b_data;
      w_diff      = w_big[14:9] - w_sml[14:9];
      al_big_sign = w_big[15];
      al_big_exp  = w_big[14:9];
      al_big_sig  = unpack_sig(w_big);
      al_sml_sign = w_sml[15];
      al_sml_sig  = (w_diff >= 6'd11) ? '0 : (unpack_sig(w_sml) >> w_diff);
   end

   always_comb begin
      w_eff_sub = big_sign ^ sml_sign;
      w_swap    = (sml_sig > big_sig);
      if (!w_eff_sub)   w_raw = big_sig + sml_sig;
      else if (w_swap)  w_raw = sml_sig - big_sig;
      else              w_raw = big_sig - sml_sig;
      w_carry  = w_raw[SIG_W-1];
      sum_sign = (w_eff_sub && w_swap) ? sml_sign : big_sign;
      sum_zero = (w_raw == '0);
      sum_sat  = w_carry && (big_exp == EXP_W'(EXP_MAX));
      if (sum_sat) begin
         sum_exp = SAT_MAG[14:9];
         sum_sig = {1'b1, SAT_MAG[MANT_W-1:0]};
      end else begin
         sum_exp = big_exp + {{(EXP_W-1){1'b0}}, w_carry};
         sum_sig = w_carry ? w_raw[SIG_W-1:1] : w_raw[9:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/fp_acc_stream.sv
// ============================================================================
//  Module      : fp_acc_stream
//  Description : Frame-based DLFloat16 stream accumulator with truncating
//                add, serial normalisation, saturation and valid/ready I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_acc_stream
   import fp_pkg::*;
#(
   parameter int NORM_MAX = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_ovf
);

   localparam int c_CNT_W = $clog2(NORM_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NORM_MAX - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_rst_done;
   logic [15:0]        r_op;
   logic               r_last;
   logic [15:0]        r_acc;
   logic               r_ovf;
   logic               r_big_sign;
   logic [EXP_W-1:0]   r_big_exp;
   logic [SIG_W-1:0]   r_big_sig;
   logic               r_sml_sign;
   logic [SIG_W-1:0]   r_sml_sig;
   logic               r_norm_sign;
   logic [EXP_W-1:0]   r_norm_exp;
   logic [9:0]         r_norm_sig;
   logic [c_CNT_W-1:0] r_norm_cnt;

   logic               w_al_big_sign;
   logic [EXP_W-1:0]   w_al_big_exp;
   logic [SIG_W-1:0]   w_al_big_sig;
   logic               w_al_sml_sign;
   logic [SIG_W-1:0]   w_al_sml_sig;
   logic               w_sum_sign;
   logic [EXP_W-1:0]   w_sum_exp;
   logic [9:0]         w_sum_sig;
   logic               w_sum_zero;
   logic               w_sum_sat;

   logic               w_add_norm;
   logic [9:0]         w_norm_sig_shl;
   logic [EXP_W-1:0]   w_norm_exp_dec;
   logic               w_norm_flush;
   logic               w_norm_done;

   fp_sig_addsub u_addsub (
      .a_data      (r_acc),
      .b_data      (r_op),
      .al_big_sign (w_al_big_sign),
      .al_big_exp  (w_al_big_exp),
      .al_big_sig  (w_al_big_sig),
      .al_sml_sign (w_al_sml_sign),
      .al_sml_sig  (w_al_sml_sig),
      .big_sign    (r_big_sign),
      .big_exp     (r_big_exp),
      .big_sig     (r_big_sig),
      .sml_sign    (r_sml_sign),
      .sml_sig     (r_sml_sig),
      .sum_sign    (w_sum_sign),
      .sum_exp     (w_sum_exp),
      .sum_sig     (w_sum_sig),
      .sum_zero    (w_sum_zero),
      .sum_sat     (w_sum_sat)
   );

   assign w_add_norm     = !w_sum_zero && !w_sum_sig[9];
   assign w_norm_sig_shl = {r_norm_sig[8:0], 1'b0};
   assign w_norm_exp_dec = r_norm_exp - 6'd1;
   assign w_norm_flush   = (w_norm_exp_dec == '0);
   assign w_norm_done    = w_norm_sig_shl[9] || (r_norm_cnt == c_CNT_LAST);

   assign out_data = r_acc;
   assign out_ovf  = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // r_rst_done keeps in_ready low until the first edge after reset release
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = r_rst_done;
            if (in_valid && r_rst_done) w_state_nxt = ALIGN;
         end
         ALIGN: w_state_nxt = ADD;
         ADD: begin
            if (w_add_norm) w_state_nxt = NORM;
            else            w_state_nxt = r_last ? DONE : IDLE;
         end
         NORM: begin
            if (w_norm_flush || w_norm_done) w_state_nxt = r_last ? DONE : IDLE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_done  <= 1'b0;
         r_op        <= '0;
         r_last      <= 1'b0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_big_sign  <= 1'b0;
         r_big_exp   <= '0;
         r_big_sig   <= '0;
         r_sml_sign  <= 1'b0;
         r_sml_sig   <= '0;
         r_norm_sign <= 1'b0;
         r_norm_exp  <= '0;
         r_norm_sig  <= '0;
         r_norm_cnt  <= '0;
      end else begin
         r_rst_done <= 1'b1;
         case (r_state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  r_op   <= in_data;
                  r_last <= in_last;
               end
            end
            ALIGN: begin
               r_big_sign <= w_al_big_sign;
               r_big_exp  <= w_al_big_exp;
               r_big_sig  <= w_al_big_sig;
               r_sml_sign <= w_al_sml_sign;
               r_sml_sig  <= w_al_sml_sig;
            end
            ADD: begin
               if (w_sum_sat) r_ovf <= 1'b1;
               if (w_sum_zero) begin
                  r_acc <= '0;
               end else if (!w_add_norm) begin
                  r_acc <= {w_sum_sign, w_sum_exp, w_sum_sig[8:0]};
               end else begin
                  r_norm_sign <= w_sum_sign;
                  r_norm_exp  <= w_sum_exp;
                  r_norm_sig  <= w_sum_sig;
                  r_norm_cnt  <= '0;
               end
            end
            NORM: begin
               r_norm_sig <= w_norm_sig_shl;
               r_norm_exp <= w_norm_exp_dec;
               r_norm_cnt <= r_norm_cnt + 1'b1;
               if (w_norm_flush)     r_acc <= '0;
               else if (w_norm_done) r_acc <= {r_norm_sign, w_norm_exp_dec, w_norm_sig_shl[8:0]};
            end
            DONE: begin
               if (out_ready) begin
                  r_acc <= '0;
                  r_ovf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp_acc_stream.sv
// ============================================================================
//  Module      : tb_fp_acc_stream
//  Description : Directed self-checking bench for the DLFloat16 accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_acc_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_ovf;

   int n_checks = 0;
   int n_fails  = 0;

   fp_acc_stream #(.NORM_MAX(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("send_timeout", 16'(in_ready), 16'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) check_eq("out_timeout", 16'(out_valid), 16'd1);
   endtask

   task automatic take(input string tag, input logic [15:0] exp_d, input logic exp_o);
      int lat;
      wait_out(lat);
      check_eq({tag, "_data"}, out_data, exp_d);
      check_eq({tag, "_ovf"}, 16'(out_ovf), 16'(exp_o));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [15:0] held;

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", 16'(in_ready), 16'd0);
      check_eq("rst_out_valid", 16'(out_valid), 16'd0);
      check_eq("rst_out_data", out_data, 16'h0000);
      check_eq("rst_out_ovf", 16'(out_ovf), 16'd0);
      rst_n = 1'b1;

      // 1.0 + 2.0 = 3.0, no normalisation: 2 cycles after acceptance
      send(16'h3E00, 1'b0);
      send(16'h4000, 1'b1);
      wait_out(lat);
      check_eq("add_lat", 16'(lat), 16'd2);
      take("add_1p2", 16'h4100, 1'b0);

      send(16'h3E00, 1'b0);
      send(16'hBE00, 1'b1);
      take("cancel", 16'h0000, 1'b0);

      // 3.0 - 2.0 needs exactly one NORM cycle
      send(16'h4100, 1'b0);
      send(16'hC000, 1'b1);
      wait_out(lat);
      check_eq("norm_lat", 16'(lat), 16'd3);
      take("sub_3m2", 16'h3E00, 1'b0);

      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b1);
      take("sat", 16'h7FFF, 1'b1);
      send(16'h3E00, 1'b1);
      take("after_sat", 16'h3E00, 1'b0);

      send(16'h4000, 1'b0);
      send(16'h2800, 1'b1);
      take("diff12", 16'h4000, 1'b0);

      send(16'h0123, 1'b1);
      take("single_zero", 16'h0000, 1'b0);
      send(16'hBE00, 1'b1);
      take("single_neg", 16'hBE00, 1'b0);

      send(16'h3E00, 1'b0);
      send(16'hC100, 1'b1);
      take("sign_flip", 16'hC000, 1'b0);

      send(16'h0300, 1'b0);
      send(16'h8200, 1'b1);
      take("underflow", 16'h0000, 1'b0);

      send(16'h3E00, 1'b0);
      send(16'h3E00, 1'b0);
      send(16'h3E00, 1'b1);
      take("three_ones", 16'h4100, 1'b0);

      send(16'h3E01, 1'b0);
      send(16'h4000, 1'b1);
      take("truncate", 16'h4100, 1'b0);

      // back-pressure in DONE
      send(16'h3E00, 1'b0);
      send(16'h4000, 1'b1);
      wait_out(lat);
      held = out_data;
      check_eq("bp_value", held, 16'h4100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_stable", out_data, held);
         check_eq("bp_valid", 16'(out_valid), 16'd1);
         check_eq("bp_in_ready", 16'(in_ready), 16'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("bp_release_valid", 16'(out_valid), 16'd0);
      check_eq("bp_release_in_ready", 16'(in_ready), 16'd1);

      // reset while the second operand is normalising
      send(16'h4100, 1'b0);
      send(16'hC000, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_in_ready", 16'(in_ready), 16'd0);
      check_eq("midrst_out_valid", 16'(out_valid), 16'd0);
      check_eq("midrst_out_data", out_data, 16'h0000);
      check_eq("midrst_out_ovf", 16'(out_ovf), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h4000, 1'b1);
      take("post_rst", 16'h4000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
